dl11_fifo_regs: RTL and testbench
=================================

Name: dl11_fifo_regs

Overview:
- Parametrised successor to the single-character DL11 console register block.
- Presents the four DL11 iopage registers (RCSR, RBUF, XCSR, XBUF) at a programmable base and vector.
- Buffers receive and transmit bytes in FIFOs, reports overrun, supports maintenance loopback, and runs a two-source interrupt request/acknowledge handshake.
- Connects to an external byte-level UART through valid/ready strobes. Baud generation and serialisation stay outside this block.

Parameters:
- BASE_ADDR, 13'o17560, iopage word address of RCSR; RBUF = +2, XCSR = +4, XBUF = +6.
- VECTOR, 8'o60, receive vector; transmit vector is VECTOR+4.
- RX_AW, 4, log2 of receive FIFO depth (16 entries).
- TX_AW, 2, log2 of transmit FIFO depth (4 entries).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- iopage_addr  in  13  iopage byte address.
- data_in  in  16  write data.
- data_out  out  16  read data; 0 when not (iopage_rd & decode).
- decode  out  1  combinational; high when iopage_addr is in BASE_ADDR..BASE_ADDR+7.
- iopage_rd, iopage_wr, iopage_byte_op  in  1 each  bus strobes; may be held for several cycles.
- interrupt  out  1  registered interrupt request.
- interrupt_ack  in  1  one-cycle grant of the currently presented vector.
- vector  out  8  VECTOR (rx), VECTOR+4 (tx), else 0.
- tx_data  out  8  byte to UART, valid while tx_valid.
- tx_valid  out  1  transmit FIFO non-empty and loopback off.
- tx_ready  in  1  UART accepts tx_data when tx_valid & tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- rx_ferr  in  1  framing error for the rx_data byte, qualified by rx_valid.

Behaviour:
- Access edges: rd_edge = iopage_rd & decode & ~rd_q; wr_edge likewise. rd_q and wr_q are the previous-cycle strobes. Side effects (push, pop, clear) happen only on an edge, never repeatedly while a strobe is held.
- Byte writes: iopage_addr[0]=1 with iopage_byte_op writes the high byte. The high bytes of every register are read-only, so these writes are ignored. Word writes and even-address byte writes act on the low byte.
- RCSR read: {ERR, 2'b0, cnt[4:0], DONE, RIE, 6'b0}.
  - DONE = rx FIFO non-empty.
  - cnt = min(rx count, 31).
  - ERR = sticky overrun OR head-entry framing error.
  - Write sets RIE from data_in[6].
- RBUF read: {ERR, OVR, 5'b0, FE, data[7:0]} of the head entry.
  - The rd_edge pops the head if non-empty; the value shown is the pre-pop head.
  - The rd_edge also clears the sticky OVR.
  - Reading an empty FIFO returns {OVR, 7'b0, 8'h00} with no pop. Bit 15 (ERR) = OVR, bit 14 (OVR) = 0.
  - Writes are ignored.
- XCSR read: {8'b0, RDY, TIE, 3'b0, MAINT, 2'b0}.
  - RDY = tx FIFO not full.
  - Write loads TIE = data_in[6] and MAINT = data_in[2].
- XBUF write: wr_edge pushes data_in[7:0] if not full. A push to a full FIFO is dropped silently. XBUF read returns {8'b0, last written byte}.
- Rx push source: the rx_valid strobe, or a tx FIFO pop in loopback. Each entry stores 9 bits: FE plus the byte. Loopback bytes carry FE=0.
- Rx FIFO full: a push without a simultaneous pop drops the byte and sets OVR. Push and pop in the same cycle when full are both performed; count is unchanged and no overrun occurs.
- Tx drain:
  - MAINT=0: pop on tx_valid & tx_ready.
  - MAINT=1: tx_valid=0, and one byte per cycle moves from the tx FIFO into the rx FIFO. Normal rx-full rules apply.
  - rx_valid takes precedence over loopback in the same cycle; the loopback byte waits one cycle.
- Interrupt request state: rx_req and tx_req, both registered.
  - rx_req is set on the cycle (DONE & RIE) goes 0->1.
  - tx_req is set on the cycle (RDY & TIE) goes 0->1. Setting TIE while RDY=1 counts as a rising edge.
  - A request clears when its condition falls, or on interrupt_ack while that source is presented on vector.
  - A set and a clear in the same cycle resolve to clear.
- Interrupt outputs: interrupt = rx_req | tx_req, one-cycle latency from the condition edge. vector presents rx when rx_req is set, else tx; combinational from the req flops.
- Reset values:
  - FIFOs flushed; count 0.
  - RIE = TIE = MAINT = OVR = 0.
  - rx_req = tx_req = 0.
  - XBUF shadow = 0.
  - rd_q = wr_q = 0.
  - All outputs 0, except tx_data = don't-care (drive 0).
- Reset mid-transfer discards queued bytes. The UART is not notified.
- Pointers wrap modulo depth. Count width is AW+1.

Test Plan:
- Reset, then read each register -> RCSR=0, RBUF=0, XCSR=16'o200 (RDY), XBUF=0; interrupt=0; vector=0.
- Strobe rx_valid with 8'h41, 8'h42; read RCSR -> 16'o1200 (cnt=2, DONE); RBUF -> 16'h0041, then 16'h0042; RCSR -> 0. Holding iopage_rd 3 cycles pops only once.
- Send 17 rx bytes with RX_AW=4, no reads -> RCSR = 16'o110200 (ERR, cnt=16, DONE). First RBUF read -> bit15, bit14 set and byte 1; next read has OVR=0.
- Write XCSR=16'o100 with RDY=1 -> interrupt=1 next cycle, vector=8'o64. Pulse interrupt_ack -> interrupt=0. Vector stays 0 until TIE or RDY re-rises.
- With tx_ready=0, write 4 bytes -> RDY=0 and the 5th write is dropped. Raise tx_ready -> 4 bytes emitted in order, RDY=1.
- RIE=1, MAINT=1; write XBUF=8'h55 -> rx DONE, rx_req set; vector=8'o60 takes priority over a pending tx request. After ack, vector=8'o64. RBUF -> 16'h0055.

Source files
------------

// File: rtl/dl11_fifo_regs_if.sv
// DL11 register block bus bundle: iopage access, interrupt handshake, UART byte strobes.
// Latency: none (wires only).
// Backpressure: tx uses valid/ready; rx is a one-cycle strobe with no stall.
// Ports: master = CPU/UART side, slave = dl11_fifo_regs.
interface dl11_fifo_regs_if;
  logic [12:0] iopage_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        decode;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic        interrupt;
  logic        interrupt_ack;
  logic [7:0]  vector;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;

  modport master (
    output iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    output interrupt_ack, tx_ready, rx_data, rx_valid, rx_ferr,
    input  data_out, decode, interrupt, vector, tx_data, tx_valid
  );

  modport slave (
    input  iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op,
    input  interrupt_ack, tx_ready, rx_data, rx_valid, rx_ferr,
    output data_out, decode, interrupt, vector, tx_data, tx_valid
  );
endinterface

// File: rtl/dl11_fifo_regs.sv
// DL11 console registers (RCSR/RBUF/XCSR/XBUF) with rx/tx byte FIFOs, overrun, loopback, two-source interrupts.
// Latency: register reads combinational; FIFO push/pop and interrupt request one clock after the causing edge.
// Backpressure: tx_valid held until tx_ready; rx bytes arriving to a full FIFO are dropped and flagged as overrun.
// Ports: clk, reset (sync, active high), bus (dl11_fifo_regs_if.slave) carrying iopage, interrupt and UART signals.

// Generic FIFO: show-ahead head, count AW+1 bits wide, pointers wrap modulo depth.
// Latency: write visible at head one clock after push.
// Backpressure: a push while full is accepted only together with a pop.
module dl11_fifo_regs_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full   = count[AW];
  assign empty  = (count == '0);
  assign do_rd  = rd_rdy & ~empty;
  assign do_wr  = wr_vld & (~full | do_rd);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: flushing the pointers is enough to discard it
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module dl11_fifo_regs #(
  parameter logic [12:0] BASE_ADDR = 13'o17560,
  parameter logic [7:0]  VECTOR    = 8'o60,
  parameter int          RX_AW     = 4,
  parameter int          TX_AW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dl11_fifo_regs_if.slave  bus
);
  localparam logic [1:0] REG_RCSR  = 2'd0;
  localparam logic [1:0] REG_RBUF  = 2'd1;
  localparam logic [1:0] REG_XCSR  = 2'd2;
  localparam logic [1:0] REG_XBUF  = 2'd3;
  localparam logic [7:0] TX_VECTOR = VECTOR + 8'd4;

  // Address decode and access edges
  logic [12:0] addr_off;
  logic        dec;
  logic [1:0]  reg_sel;
  logic        hi_byte;
  logic        rd_q;
  logic        wr_q;
  logic        rd_edge;
  logic        wr_lo;

  assign addr_off   = bus.iopage_addr - BASE_ADDR;
  assign dec        = (bus.iopage_addr >= BASE_ADDR) && (addr_off < 13'd8);
  assign bus.decode = dec;
  assign reg_sel    = addr_off[2:1];
  assign hi_byte    = bus.iopage_addr[0] & bus.iopage_byte_op;
  assign rd_edge    = bus.iopage_rd & dec & ~rd_q;
  // High bytes are read-only, so an odd byte write has no effect at all
  assign wr_lo      = bus.iopage_wr & dec & ~wr_q & ~hi_byte;

  logic [7:0] unused_data_hi;
  assign unused_data_hi = bus.data_in[15:8];

  // Control state
  logic       rie;
  logic       tie;
  logic       maint;
  logic       ovr;
  logic [7:0] xbuf_shadow;

  // Receive FIFO: entry = {FE, byte}
  logic [8:0]     rx_push_dat;
  logic [8:0]     rx_head;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;
  logic [RX_AW:0] rx_count;

  // Transmit FIFO
  logic [7:0]     tx_head;
  logic           tx_push;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;
  logic [TX_AW:0] tx_cnt_unused;

  logic rx_done;
  logic rdy;
  logic rbuf_rd;
  logic xbuf_wr;
  logic lb_pop;
  logic overrun;
  logic err;

  assign rx_done = ~rx_empty;
  assign rdy     = ~tx_full;
  assign rbuf_rd = rd_edge & (reg_sel == REG_RBUF);
  assign rx_pop  = rbuf_rd & rx_done;
  assign xbuf_wr = wr_lo & (reg_sel == REG_XBUF);

  // A live rx strobe owns the rx push port; a loopback byte stays in the
  // tx FIFO until the next free cycle.
  assign lb_pop      = maint & ~tx_empty & ~bus.rx_valid;
  assign tx_pop      = maint ? lb_pop : (bus.tx_valid & bus.tx_ready);
  assign tx_push     = xbuf_wr & ~tx_full;
  assign rx_push     = bus.rx_valid | lb_pop;
  assign rx_push_dat = bus.rx_valid ? {bus.rx_ferr, bus.rx_data} : {1'b0, tx_head};
  // Full with a same-cycle pop is not an overrun: the FIFO takes both
  assign overrun     = rx_push & rx_full & ~rx_pop;
  assign err         = ovr | (rx_done & rx_head[8]);

  assign bus.tx_valid = ~tx_empty & ~maint;
  assign bus.tx_data  = bus.tx_valid ? tx_head : 8'h00;

  dl11_fifo_regs_fifo #(.W(9), .AW(RX_AW)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (rx_push),
    .wr_dat (rx_push_dat),
    .rd_rdy (rx_pop),
    .rd_dat (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  dl11_fifo_regs_fifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (tx_push),
    .wr_dat (bus.data_in[7:0]),
    .rd_rdy (tx_pop),
    .rd_dat (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_cnt_unused)
  );

  // RCSR count field saturates at 31 for deep receive FIFOs
  logic [31:0] rx_count_w;
  logic [4:0]  rx_cnt5;
  assign rx_count_w = 32'(rx_count);
  assign rx_cnt5    = (rx_count_w > 32'd31) ? 5'd31 : rx_count_w[4:0];

  // Read mux
  always_comb begin
    bus.data_out = 16'h0000;
    if (bus.iopage_rd && dec) begin
      case (reg_sel)
        REG_RCSR: bus.data_out = {err, 2'b00, rx_cnt5, rx_done, rie, 6'b000000};
        REG_RBUF: bus.data_out = rx_done ? {err, ovr, 5'b00000, rx_head}
                                         : {ovr, 15'h0000};
        REG_XCSR: bus.data_out = {8'h00, rdy, tie, 3'b000, maint, 2'b00};
        default:  bus.data_out = {8'h00, xbuf_shadow};
      endcase
    end
  end

  // Register writes, overrun flag, strobe history
  always_ff @(posedge clk) begin
    if (reset) begin
      rie         <= 1'b0;
      tie         <= 1'b0;
      maint       <= 1'b0;
      ovr         <= 1'b0;
      xbuf_shadow <= 8'h00;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      rd_q <= bus.iopage_rd;
      wr_q <= bus.iopage_wr;
      if (wr_lo && reg_sel == REG_RCSR) rie <= bus.data_in[6];
      if (wr_lo && reg_sel == REG_XCSR) begin
        tie   <= bus.data_in[6];
        maint <= bus.data_in[2];
      end
      if (xbuf_wr) xbuf_shadow <= bus.data_in[7:0];
      if (overrun)      ovr <= 1'b1;
      else if (rbuf_rd) ovr <= 1'b0;
    end
  end

  // Interrupt requests: set on the rising edge of each source condition,
  // cleared when the condition drops or the presented source is acknowledged.
  logic rx_cond;
  logic tx_cond;
  logic rx_cond_q;
  logic tx_cond_q;
  logic rx_req;
  logic tx_req;
  logic rx_req_n;
  logic tx_req_n;

  assign rx_cond = rx_done & rie;
  assign tx_cond = rdy & tie;

  always_comb begin
    rx_req_n = rx_req;
    tx_req_n = tx_req;
    if (rx_cond && !rx_cond_q) rx_req_n = 1'b1;
    if (tx_cond && !tx_cond_q) tx_req_n = 1'b1;
    // Clears are applied last so they win over a same-cycle set
    if (!rx_cond || (bus.interrupt_ack && rx_req)) rx_req_n = 1'b0;
    if (!tx_cond || (bus.interrupt_ack && !rx_req && tx_req)) tx_req_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cond_q     <= 1'b0;
      tx_cond_q     <= 1'b0;
      rx_req        <= 1'b0;
      tx_req        <= 1'b0;
      bus.interrupt <= 1'b0;
    end else begin
      rx_cond_q     <= rx_cond;
      tx_cond_q     <= tx_cond;
      rx_req        <= rx_req_n;
      tx_req        <= tx_req_n;
      bus.interrupt <= rx_req_n | tx_req_n;
    end
  end

  // Receive source has priority on the vector
  assign bus.vector = rx_req ? VECTOR : (tx_req ? TX_VECTOR : 8'h00);
endmodule

// File: tb/tb_dl11_fifo_regs.sv
// Bench for dl11_fifo_regs: directed scenarios with literal expectations, then randomized traffic.
// Latency: outputs compared every negedge against a queue-based model updated at each posedge.
// Backpressure: tx_ready, rx_valid and bus strobes randomized, including overrun and loopback.
module tb_dl11_fifo_regs;
  localparam logic [12:0] BASE  = 13'o17560;
  localparam logic [12:0] A_RCSR = BASE;
  localparam logic [12:0] A_RBUF = BASE + 13'd2;
  localparam logic [12:0] A_XCSR = BASE + 13'd4;
  localparam logic [12:0] A_XBUF = BASE + 13'd6;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dl11_fifo_regs_if bus_if ();

  dl11_fifo_regs #(
    .BASE_ADDR (13'o17560),
    .VECTOR    (8'o60),
    .RX_AW     (4),
    .TX_AW     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_ok;
  logic [8:0] m_rxq[$];
  logic [7:0] m_txq[$];
  bit         m_rie, m_tie, m_maint, m_ovr;
  logic [7:0] m_shadow;
  bit         m_rd_q, m_wr_q;
  bit         m_rx_req, m_tx_req, m_prev_rxc, m_prev_txc;

  function automatic bit m_in_range(input logic [12:0] a);
    return (a >= BASE) && (a <= BASE + 13'd7);
  endfunction

  function automatic int m_sel(input logic [12:0] a);
    return int'((a - BASE) >> 1) & 3;
  endfunction

  function automatic logic [15:0] m_data_out();
    int         n;
    bit         done;
    bit         err;
    logic [4:0] c5;
    if (!(bus_if.iopage_rd && m_in_range(bus_if.iopage_addr))) return 16'h0000;
    n    = m_rxq.size();
    done = (n > 0);
    err  = m_ovr || (done && m_rxq[0][8]);
    c5   = (n > 31) ? 5'd31 : 5'(n);
    case (m_sel(bus_if.iopage_addr))
      0: return {err, 2'b00, c5, done, m_rie, 6'b000000};
      1: return done ? {err, m_ovr, 5'b00000, m_rxq[0]} : {m_ovr, 15'h0000};
      2: return {8'h00, (m_txq.size() < 4), m_tie, 3'b000, m_maint, 2'b00};
      default: return {8'h00, m_shadow};
    endcase
  endfunction

  always @(posedge clk) begin
    bit         dec, hi, rde, wre, done, rdy, rxc, txc, nrx, ntx, pop, lb, txpop, txfull;
    int         sel;
    logic [7:0] lbbyte;
    if (reset) begin
      m_rxq.delete();
      m_txq.delete();
      m_rie = 0; m_tie = 0; m_maint = 0; m_ovr = 0;
      m_shadow = 8'h00;
      m_rd_q = 0; m_wr_q = 0;
      m_rx_req = 0; m_tx_req = 0; m_prev_rxc = 0; m_prev_txc = 0;
      m_ok = 1;
    end else if (m_ok) begin
      dec  = m_in_range(bus_if.iopage_addr);
      sel  = m_sel(bus_if.iopage_addr);
      hi   = bus_if.iopage_addr[0] && bus_if.iopage_byte_op;
      rde  = bus_if.iopage_rd && dec && !m_rd_q;
      wre  = bus_if.iopage_wr && dec && !m_wr_q && !hi;
      done = m_rxq.size() > 0;
      rdy  = m_txq.size() < 4;
      rxc  = done && m_rie;
      txc  = rdy && m_tie;
      nrx = m_rx_req;
      ntx = m_tx_req;
      if (rxc && !m_prev_rxc) nrx = 1;
      if (txc && !m_prev_txc) ntx = 1;
      if (!rxc || (bus_if.interrupt_ack && m_rx_req)) nrx = 0;
      if (!txc || (bus_if.interrupt_ack && !m_rx_req && m_tx_req)) ntx = 0;
      m_rx_req = nrx; m_tx_req = ntx; m_prev_rxc = rxc; m_prev_txc = txc;

      pop    = rde && sel == 1 && done;
      lb     = m_maint && m_txq.size() > 0 && !bus_if.rx_valid;
      txpop  = m_maint ? lb : (m_txq.size() > 0 && bus_if.tx_ready);
      txfull = m_txq.size() == 4;
      lbbyte = (m_txq.size() > 0) ? m_txq[0] : 8'h00;
      if (rde && sel == 1) m_ovr = 0;
      if (pop) void'(m_rxq.pop_front());
      if (bus_if.rx_valid || lb) begin
        if (m_rxq.size() < 16)
          m_rxq.push_back(bus_if.rx_valid ? {bus_if.rx_ferr, bus_if.rx_data} : {1'b0, lbbyte});
        else
          m_ovr = 1;
      end
      if (txpop) void'(m_txq.pop_front());
      if (wre && sel == 3) begin
        m_shadow = bus_if.data_in[7:0];
        if (!txfull) m_txq.push_back(bus_if.data_in[7:0]);
      end
      if (wre && sel == 0) m_rie = bus_if.data_in[6];
      if (wre && sel == 2) begin
        m_tie   = bus_if.data_in[6];
        m_maint = bus_if.data_in[2];
      end
      m_rd_q = bus_if.iopage_rd;
      m_wr_q = bus_if.iopage_wr;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    bit tv;
    if (m_ok) begin
      tv = (m_txq.size() > 0) && !m_maint;
      check("decode", 32'(bus_if.decode), 32'(m_in_range(bus_if.iopage_addr)));
      check("data_out", 32'(bus_if.data_out), 32'(m_data_out()));
      check("interrupt", 32'(bus_if.interrupt), 32'(m_rx_req || m_tx_req));
      check("vector", 32'(bus_if.vector),
            m_rx_req ? 32'o60 : (m_tx_req ? 32'o64 : 32'd0));
      check("tx_valid", 32'(bus_if.tx_valid), 32'(tv));
      if (tv) check("tx_data", 32'(bus_if.tx_data), 32'(m_txq[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_if.iopage_addr    = 13'd0;
    bus_if.data_in        = 16'h0000;
    bus_if.iopage_rd      = 1'b0;
    bus_if.iopage_wr      = 1'b0;
    bus_if.iopage_byte_op = 1'b0;
    bus_if.interrupt_ack  = 1'b0;
    bus_if.tx_ready       = 1'b0;
    bus_if.rx_data        = 8'h00;
    bus_if.rx_valid       = 1'b0;
    bus_if.rx_ferr        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic bus_rd(input logic [12:0] a, input int hold, output logic [15:0] d);
    bus_if.iopage_addr = a;
    bus_if.iopage_rd   = 1'b1;
    @(negedge clk);
    d = bus_if.data_out;
    repeat (hold) tick();
    bus_if.iopage_rd = 1'b0;
    tick();
  endtask

  task automatic bus_wr(input logic [12:0] a, input logic [15:0] d);
    bus_if.iopage_addr = a;
    bus_if.data_in     = d;
    bus_if.iopage_wr   = 1'b1;
    tick();
    bus_if.iopage_wr = 1'b0;
    tick();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick();
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic sample_irq(input string tag, input logic exp_irq, input logic [7:0] exp_vec);
    @(negedge clk);
    check({tag, "_irq"}, 32'(bus_if.interrupt), 32'(exp_irq));
    check({tag, "_vec"}, 32'(bus_if.vector), 32'(exp_vec));
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  got[$];
    int          op;
    errors = 0;
    checks = 0;
    m_ok   = 0;
    idle_bus();
    reset = 1'b1;
    tick();
    do_reset();

    // Reset state of every register
    bus_rd(A_RCSR, 1, d); check("rst_rcsr", 32'(d), 32'h0000);
    bus_rd(A_RBUF, 1, d); check("rst_rbuf", 32'(d), 32'h0000);
    bus_rd(A_XCSR, 1, d); check("rst_xcsr", 32'(d), 32'o200);
    bus_rd(A_XBUF, 1, d); check("rst_xbuf", 32'(d), 32'h0000);
    sample_irq("rst", 1'b0, 8'h00);

    // Two received bytes; a held read pops once
    rx_byte(8'h41);
    rx_byte(8'h42);
    tick();
    bus_rd(A_RCSR, 1, d); check("rx2_rcsr", 32'(d), 32'o1200);
    bus_rd(A_RBUF, 3, d); check("rx2_rbuf0", 32'(d), 32'h0041);
    bus_rd(A_RBUF, 1, d); check("rx2_rbuf1", 32'(d), 32'h0042);
    bus_rd(A_RCSR, 1, d); check("rx2_empty", 32'(d), 32'h0000);

    // Overrun: 17 bytes into 16 entries
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      bus_if.rx_data  = 8'(i);
      bus_if.rx_valid = 1'b1;
      tick();
    end
    bus_if.rx_valid = 1'b0;
    tick();
    bus_rd(A_RCSR, 1, d); check("ovr_rcsr", 32'(d), 32'o110200);
    bus_rd(A_RBUF, 1, d); check("ovr_rbuf0", 32'(d), 32'hC001);
    bus_rd(A_RBUF, 1, d); check("ovr_rbuf1", 32'(d), 32'h0002);

    // Transmit interrupt from TIE rising while RDY
    do_reset();
    bus_wr(A_XCSR, 16'o100);
    sample_irq("tie", 1'b1, 8'o64);
    bus_if.interrupt_ack = 1'b1;
    tick();
    bus_if.interrupt_ack = 1'b0;
    sample_irq("tie_ack", 1'b0, 8'h00);
    repeat (3) tick();
    sample_irq("tie_hold", 1'b0, 8'h00);

    // Transmit FIFO fill, drop, drain
    do_reset();
    for (int i = 0; i < 5; i++) bus_wr(A_XBUF, 16'(8'h10 + i));
    bus_rd(A_XCSR, 1, d); check("txfull_xcsr", 32'(d), 32'h0000);
    bus_if.tx_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_if.tx_valid) got.push_back(bus_if.tx_data);
      tick();
    end
    bus_if.tx_ready = 1'b0;
    check("tx_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("tx_byte", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(8'h10 + i));
    bus_rd(A_XCSR, 1, d); check("txdrain_xcsr", 32'(d), 32'o200);

    // Loopback with both interrupt sources pending
    do_reset();
    bus_wr(A_RCSR, 16'o100);
    bus_wr(A_XCSR, 16'o104);
    sample_irq("lb_tx", 1'b1, 8'o64);
    bus_wr(A_XBUF, 16'h0055);
    tick();
    sample_irq("lb_rx", 1'b1, 8'o60);
    bus_if.interrupt_ack = 1'b1;
    tick();
    bus_if.interrupt_ack = 1'b0;
    sample_irq("lb_ack", 1'b1, 8'o64);
    bus_rd(A_RBUF, 1, d); check("lb_rbuf", 32'(d), 32'h0055);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      bus_if.rx_valid      = ($urandom_range(0, 99) < 25);
      bus_if.rx_data       = 8'($urandom);
      bus_if.rx_ferr       = ($urandom_range(0, 99) < 15);
      bus_if.tx_ready      = 1'($urandom_range(0, 1));
      bus_if.interrupt_ack = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 40) begin
        op = int'($urandom_range(0, 3));
        bus_if.iopage_rd      = (op == 1);
        bus_if.iopage_wr      = (op == 2);
        bus_if.iopage_addr    = BASE - 13'd2 + 13'($urandom_range(0, 11));
        bus_if.data_in        = 16'($urandom);
        bus_if.iopage_byte_op = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 999) < 3);
      tick();
    end
    reset = 1'b0;
    idle_bus();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
